id_ex_elastic_stage: RTL and testbench

//  Parametrised ID->EX pipeline register with a valid/ready handshake, a 2-entry skid buffer and flush.

---
 rtl/id_ex_elastic_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_elastic_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_elastic_stage.sv
// ID->EX pipeline register with valid/ready handshake, a one-deep skid entry and flush.
// CTRL bits are cleared whenever the stage holds no bundle; DATA bits keep stale contents.
module id_ex_elastic_stage #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              in_ready_q;
    logic              out_valid_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic xfer;

    logic main_load;
    logic main_sel_skid;
    logic main_clr;
    logic skid_load;
    logic skid_clr;

    assign accept = in_valid & in_ready_q;
    assign xfer   = out_valid_q & out_ready;

    // State register; the encoding doubles as the occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every handshake event
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) state_d = BUSY;
                end
                BUSY: begin
                    if (accept && !xfer)      state_d = FULL;
                    else if (!accept && xfer) state_d = EMPTY;
                end
                FULL: begin
                    if (xfer) state_d = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Datapath steering derived from the current state and this cycle's events
    always_comb begin
        main_load     = 1'b0;
        main_sel_skid = 1'b0;
        main_clr      = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) main_load = 1'b1;
                end
                BUSY: begin
                    if (accept && xfer) main_load = 1'b1;
                    else if (accept)    skid_load = 1'b1;
                    else if (xfer)      main_clr  = 1'b1;
                end
                FULL: begin
                    if (xfer) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clr      = 1'b1;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // Handshake outputs are registered from the next state, so ready never depends on out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // Main entry: CTRL is cleared whenever main stops holding a live bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl <= '0;
            main_data <= '0;
        end else begin
            if (main_clr) begin
                main_ctrl <= '0;
            end else if (main_load) begin
                main_ctrl <= main_sel_skid ? skid_ctrl : in_ctrl;
            end
            if (main_load) begin
                main_data <= main_sel_skid ? skid_data : in_data;
            end
        end
    end

    // Skid entry holds the bundle accepted while main was stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (skid_clr) begin
                skid_ctrl <= '0;
            end else if (skid_load) begin
                skid_ctrl <= in_ctrl;
            end
            if (skid_load) begin
                skid_data <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = 2'(state_q);

endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// Bench for id_ex_elastic_stage: a hand-computed vector table plus a FIFO scoreboard
// that tracks every accepted bundle until EX consumes it or a flush drops it.
module tb_id_ex_elastic_stage;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned CTRL_W = 8;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    typedef struct packed {
        logic              fl;
        logic              iv;
        logic [CTRL_W-1:0] c;
        logic              ordy;
        logic              ev;
        logic [CTRL_W-1:0] ec;
        logic              er;
        logic [1:0]        eo;
    } vec_t;

    ent_t sb[$];
    vec_t vecs[20];
    int   n_checks;
    int   n_fail;

    id_ex_elastic_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the visible stage state with the scoreboard contents
    task automatic check_model(input string tag);
        logic [CTRL_W-1:0] ec;
        ec = (sb.size() > 0) ? sb[0].c : '0;
        chk({tag, "_valid"}, 128'(out_valid), 128'(sb.size() > 0));
        chk({tag, "_ready"}, 128'(in_ready), 128'(sb.size() < 2));
        chk({tag, "_occ"}, 128'(occupancy), 128'(sb.size()));
        chk({tag, "_ctrl"}, 128'(out_ctrl), 128'(ec));
        if (sb.size() > 0) chk({tag, "_data"}, 128'(out_data), 128'(sb[0].d));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 128'(out_valid), 128'(1'b0));
        chk({tag, "_ready"}, 128'(in_ready), 128'(1'b1));
        chk({tag, "_occ"}, 128'(occupancy), 128'(2'd0));
        chk({tag, "_ctrl"}, 128'(out_ctrl), 128'(8'h00));
        chk({tag, "_data"}, 128'(out_data), 128'(0));
    endtask

    // One clock: drive at negedge, settle scoreboard, check 1 time unit after posedge
    task automatic step(input logic fl, input logic iv, input logic [CTRL_W-1:0] c,
                        input logic [DATA_W-1:0] d, input logic ordy, input string tag);
        bit acc;
        bit xf;
        @(negedge clk);
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        acc = iv && (sb.size() < 2);
        xf  = ordy && (sb.size() > 0);
        if (xf) begin
            chk({tag, "_xfer_data"}, 128'(out_data), 128'(sb[0].d));
            chk({tag, "_xfer_ctrl"}, 128'(out_ctrl), 128'(sb[0].c));
            void'(sb.pop_front());
        end
        if (fl) sb.delete();
        else if (acc) sb.push_back('{c: c, d: d});
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        vecs[0]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 2'd1};
        vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0, 2'd2};
        vecs[2]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 1'b0, 2'd2};
        vecs[3]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 1'b0, 2'd2};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1};
        vecs[7]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
        vecs[8]  = '{1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
        for (int i = 10; i < 15; i++)
            vecs[i] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[15] = '{1'b0, 1'b1, 8'h21, 1'b0, 1'b1, 8'h21, 1'b1, 2'd1};
        vecs[16] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[17] = '{1'b0, 1'b1, 8'h23, 1'b1, 1'b1, 8'h23, 1'b1, 2'd1};
        vecs[18] = '{1'b0, 1'b1, 8'h24, 1'b1, 1'b1, 8'h24, 1'b1, 2'd1};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};

        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous streaming with EX always ready
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(i + 1), rnd_data(), 1'b1, "stream");
        step(1'b0, 1'b0, '0, '0, 1'b1, "stream_drain");

        // Stall, skid, flush and idle-ctrl sequences with hand-derived expectations
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].fl, vecs[i].iv, vecs[i].c, {16{vecs[i].c}}, vecs[i].ordy, "vec");
            chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(vecs[i].ev));
            chk($sformatf("vec%0d_ctrl", i), 128'(out_ctrl), 128'(vecs[i].ec));
            chk($sformatf("vec%0d_ready", i), 128'(in_ready), 128'(vecs[i].er));
            chk($sformatf("vec%0d_occ", i), 128'(occupancy), 128'(vecs[i].eo));
        end

        // Asynchronous reset while FULL, then a fresh bundle
        step(1'b0, 1'b1, 8'h31, rnd_data(), 1'b0, "prefill");
        step(1'b0, 1'b1, 8'h32, rnd_data(), 1'b0, "prefill");
        chk("prefill_full", 128'(occupancy), 128'(2'd2));
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 8'h44, rnd_data(), 1'b0, "post_rst");
        chk("post_rst_ctrl", 128'(out_ctrl), 128'(8'h44));
        step(1'b0, 1'b0, '0, '0, 1'b1, "post_rst_drain");

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            c = 8'($urandom);
            d = rnd_data();
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), c, d,
                 ($urandom_range(0, 1) == 1), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
